// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the 32-bit accumulator CPU: word width, io_signals bit map
// and two's-complement helpers.
package acc_cpu_pkg;

    localparam int unsigned CPU_WIDTH  = 32;
    localparam int unsigned IO_IN_BIT  = 0;
    localparam int unsigned IO_OUT_BIT = 1;

    function automatic logic [CPU_WIDTH-1:0] twos_negate(input logic [CPU_WIDTH-1:0] x);
        return ~x + CPU_WIDTH'(1);
    endfunction

    // 0x8000_0000 maps onto itself: the magnitude is reported unsaturated
    function automatic logic [CPU_WIDTH-1:0] abs_val(input logic [CPU_WIDTH-1:0] x);
        return x[CPU_WIDTH-1] ? twos_negate(x) : x;
    endfunction

endpackage

// File: rtl/io_button_cond.sv
// Step button conditioning: synchronizer, optional debouncer, press/release pulse generator.
// Optional debouncer enabled by defining IO_LOGIC_DEBOUNCE_EN.
module io_button_cond #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef IO_LOGIC_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic subiu,
    output logic desceu
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic                   btn_lvl;
    logic                   btn_q;
    logic                   subiu_q;
    logic                   desceu_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

`ifdef IO_LOGIC_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    // Level flips only after btn_s has disagreed with it for DEBOUNCE_CYCLES straight cycles
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (btn_s != lvl_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = btn_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign btn_lvl = lvl_q;
`else
    assign btn_lvl = btn_s;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_q    <= 1'b0;
            subiu_q  <= 1'b0;
            desceu_q <= 1'b0;
        end else begin
            btn_q    <= btn_lvl;
            subiu_q  <= btn_lvl & ~btn_q;
            desceu_q <= ~btn_lvl & btn_q;
        end
    end

    assign subiu  = subiu_q;
    assign desceu = desceu_q;

endmodule

// File: rtl/io_logic.sv
// Processor I/O block: step-button pulses, switch-to-word conversion and display latch.
// Defining IO_LOGIC_DEBOUNCE_EN adds a debouncer on the step button.
module io_logic
    import acc_cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = CPU_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
`ifdef IO_LOGIC_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       io_signals,
    input  logic [WIDTH-1:0] out_value,
    input  logic             button,
    input  logic [WIDTH-1:0] in_data,
    input  logic             brk,
    output logic [WIDTH-1:0] input_wire,
    output logic             subiu,
    output logic             desceu,
    output logic [WIDTH-1:0] output_binary,
    output logic             negative
);

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] input_q, input_d;
    logic [WIDTH-1:0] out_bin_q, out_bin_d;
    logic             neg_q, neg_d;
    logic             unused_in;

    // IN strobe and the unused switch bits are consumed elsewhere
    assign unused_in = ^{io_signals[IO_IN_BIT], in_data[WIDTH-2:16]};

    io_button_cond #(
        .SYNC_STAGES    (SYNC_STAGES)
`ifdef IO_LOGIC_DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_button (
        .clock (clock),
        .reset (reset),
        .button(button),
        .subiu (subiu),
        .desceu(desceu)
    );

    assign mag = WIDTH'(in_data[15:0]);

    // Input word tracks the switches every cycle; display latches on OUT or while halted
    always_comb begin
        input_d   = in_data[WIDTH-1] ? twos_negate(mag) : mag;
        out_bin_d = out_bin_q;
        neg_d     = neg_q;
        if (brk || io_signals[IO_OUT_BIT]) begin
            neg_d     = out_value[WIDTH-1];
            out_bin_d = abs_val(out_value);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            input_q   <= '0;
            out_bin_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            input_q   <= input_d;
            out_bin_q <= out_bin_d;
            neg_q     <= neg_d;
        end
    end

    assign input_wire    = input_q;
    assign output_binary = out_bin_q;
    assign negative      = neg_q;

endmodule

// File: tb/tb_io_logic.sv
// Self-checking bench for io_logic: table-driven conversion/latch vectors and button sequences.
module tb_io_logic;

    localparam int unsigned W  = 32;
    localparam int unsigned SS = 2;
`ifdef IO_LOGIC_DEBOUNCE_EN
    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = SS + DB + 1;
`else
    localparam int unsigned LAT = SS + 1;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   io_signals;
    logic [W-1:0] out_value;
    logic         button;
    logic [W-1:0] in_data;
    logic         brk;
    logic [W-1:0] input_wire;
    logic         subiu;
    logic         desceu;
    logic [W-1:0] output_binary;
    logic         negative;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    io_logic #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS)
`ifdef IO_LOGIC_DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES(DB)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_signals   (io_signals),
        .out_value    (out_value),
        .button       (button),
        .in_data      (in_data),
        .brk          (brk),
        .input_wire   (input_wire),
        .subiu        (subiu),
        .desceu       (desceu),
        .output_binary(output_binary),
        .negative     (negative)
    );

    typedef struct {
        logic [W-1:0] in_data;
        logic [1:0]   io;
        logic         brk;
        logic [W-1:0] out_value;
        logic [W-1:0] exp_in;
        logic [W-1:0] exp_ob;
        logic         exp_neg;
    } vec_t;

    typedef struct {
        logic [W-1:0] in_w;
        logic [W-1:0] ob;
        logic         neg;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Press at k=0, release at k=10; record first pulse cycles and pulse counts
    task automatic press_release(input string tag, input int hold);
        int sub_n, des_n, sub_k, des_k;
        sub_n = 0; des_n = 0; sub_k = -1; des_k = -1;
        button = 1'b1;
        for (int k = 1; k <= hold + LAT + 5; k++) begin
            @(negedge clock);
            if (k == hold) button = 1'b0;
            if (subiu === 1'b1) begin sub_n++; if (sub_k < 0) sub_k = k; end
            if (desceu === 1'b1) begin des_n++; if (des_k < 0) des_k = k; end
        end
        chk({tag, "_subiu_cycle"}, W'(sub_k), W'(LAT));
        chk({tag, "_subiu_count"}, W'(sub_n), W'(1));
        chk({tag, "_desceu_cycle"}, W'(des_k), W'(hold + LAT));
        chk({tag, "_desceu_count"}, W'(des_n), W'(1));
    endtask

    initial begin
        int pulses;
        exp_t e;

        // in_data, io, brk, out_value -> input_wire, output_binary, negative
        vecs[0] = '{32'h0000_0007, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0007, 32'd0,         1'b0};
        vecs[1] = '{32'h8000_0005, 2'b10, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFFB, 32'd100,       1'b1};
        vecs[2] = '{32'h8000_0000, 2'b00, 1'b0, 32'd42,        32'h0000_0000, 32'd100,       1'b1};
        vecs[3] = '{32'h7FFF_1234, 2'b01, 1'b0, 32'd42,        32'h0000_1234, 32'd100,       1'b1};
        vecs[4] = '{32'hFFFF_0001, 2'b00, 1'b1, 32'd255,       32'hFFFF_FFFF, 32'd255,       1'b0};
        vecs[5] = '{32'h0000_FFFF, 2'b00, 1'b1, 32'd7,         32'h0000_FFFF, 32'd7,         1'b0};
        vecs[6] = '{32'h8000_FFFF, 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_0001, 32'h8000_0000, 1'b1};
        vecs[7] = '{32'h0000_0000, 2'b00, 1'b0, 32'd5,         32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[8] = '{32'h0000_8000, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_8000, 32'd0,         1'b0};
        vecs[9] = '{32'h8000_0001, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b1};

        // Reset held with button pressed, OUT strobe and brk active
        reset      = 1'b0;
        button     = 1'b1;
        io_signals = 2'b10;
        brk        = 1'b1;
        out_value  = 32'hFFFF_FF9C;
        in_data    = 32'h8000_0005;
        pulses     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (subiu !== 1'b0 || desceu !== 1'b0) pulses++;
        end
        chk("reset_pulses", W'(pulses), W'(0));
        chk("reset_input_wire", input_wire, '0);
        chk("reset_output_binary", output_binary, '0);
        chk("reset_negative", W'(negative), W'(0));
        chk("reset_subiu", W'(subiu), W'(0));
        chk("reset_desceu", W'(desceu), W'(0));

        button     = 1'b0;
        io_signals = 2'b00;
        brk        = 1'b0;
        out_value  = '0;
        in_data    = '0;
        reset      = 1'b1;
        repeat (5) @(negedge clock);

        // Vector table: drive, queue expectation, compare after the capturing edge
        foreach (vecs[i]) begin
            in_data    = vecs[i].in_data;
            io_signals = vecs[i].io;
            brk        = vecs[i].brk;
            out_value  = vecs[i].out_value;
            sb.push_back('{vecs[i].exp_in, vecs[i].exp_ob, vecs[i].exp_neg});
            @(negedge clock);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            end else begin
                e = sb.pop_front();
                chk($sformatf("vec%0d_input_wire", i), input_wire, e.in_w);
                chk($sformatf("vec%0d_output_binary", i), output_binary, e.ob);
                chk($sformatf("vec%0d_negative", i), W'(negative), W'(e.neg));
            end
        end
        io_signals = 2'b00;
        brk        = 1'b0;
        repeat (3) @(negedge clock);

        // Press at 0, release at 10
        press_release("btn", 10);

        // Long hold: a single press pulse, no repeats, no release pulse
        button = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (subiu === 1'b1) pulses++;
            if (desceu === 1'b1) pulses += 100;
        end
        chk("hold100_pulses", W'(pulses), W'(1));
        button = 1'b0;
        pulses = 0;
        for (int k = 1; k <= LAT + 5; k++) begin
            @(negedge clock);
            if (desceu === 1'b1) pulses++;
            if (subiu === 1'b1) pulses += 100;
        end
        chk("hold100_release", W'(pulses), W'(1));

`ifdef IO_LOGIC_DEBOUNCE_EN
        // A glitch shorter than the debounce window must not produce any pulse
        button = 1'b1;
        repeat (3) @(negedge clock);
        button = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (subiu === 1'b1 || desceu === 1'b1) pulses++;
        end
        chk("glitch_pulses", W'(pulses), W'(0));
        press_release("db", 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
